// File: rtl/tlb_req_arb.sv
// Round-robin arbiter sharing one TLB translation port among N_REQ requesters.
// Optional one-entry last-translation cache is enabled by defining TLB_ARB_LAST_XLATE_EN.

`ifndef DCP_VADDR
`define DCP_VADDR 48
`endif

module tlb_req_arb #(
  parameter int N_REQ = 4,
  parameter int VPN_W = `DCP_VADDR - 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*VPN_W-1:0] req_vpn,
  output logic [N_REQ-1:0]       req_ack,
  output logic [VPN_W-1:0]       req_ppn,
  output logic                   tlb_valid,
  output logic [VPN_W-1:0]       tlb_vpn,
  input  logic                   tlb_ack,
  input  logic [VPN_W-1:0]       tlb_ppn,
  input  logic                   flush,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [VPN_W-1:0] vpn_q;
  logic [VPN_W-1:0] ppn_q;

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] scan_idx;
  logic [VPN_W-1:0] cand_vpn;
  logic             lookup_hit;
  logic [VPN_W-1:0] hit_ppn;

  logic [VPN_W-1:0] vpn_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign vpn_arr[i] = req_vpn[i*VPN_W +: VPN_W];
  end

  // Scan from the highest offset down so the last match taken is the one
  // closest to rr_ptr, giving first-set-at-or-after-pointer with wrap.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
      if (scan_sum >= (IDX_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (IDX_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign cand_vpn = vpn_arr[grant_idx];

`ifdef TLB_ARB_LAST_XLATE_EN
  logic             lx_valid_q;
  logic [VPN_W-1:0] lx_vpn_q;
  logic [VPN_W-1:0] lx_ppn_q;

  assign lookup_hit = lx_valid_q && (lx_vpn_q == cand_vpn);
  assign hit_ppn    = lx_ppn_q;

  // A flush arriving together with a fill wins, leaving the entry invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx_valid_q <= 1'b0;
      lx_vpn_q   <= '0;
      lx_ppn_q   <= '0;
    end else if (state_q == REQ && tlb_ack) begin
      lx_valid_q <= !flush;
      lx_vpn_q   <= vpn_q;
      lx_ppn_q   <= tlb_ppn;
    end else if (flush) begin
      lx_valid_q <= 1'b0;
    end
  end
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign lookup_hit   = 1'b0;
  assign hit_ppn      = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = lookup_hit ? RESP : REQ;
        end
      end
      REQ: begin
        if (tlb_ack) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from state and registers only; tlb_ack never reaches
  // req_ack combinationally.
  always_comb begin
    req_ack   = '0;
    tlb_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      REQ:     tlb_valid = 1'b1;
      RESP:    req_ack[grant_q] = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign tlb_vpn = vpn_q;
  assign req_ppn = ppn_q;

  // Datapath registers. The grant and VPN are latched once in IDLE so the TLB
  // sees a stable request even if the requester misbehaves afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, since tlb_vpn and req_ppn are
      // visible outputs with defined reset values.
      rr_ptr_q <= '0;
      grant_q  <= '0;
      vpn_q    <= '0;
      ppn_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            grant_q <= grant_idx;
            vpn_q   <= cand_vpn;
            if (lookup_hit) begin
              ppn_q <= hit_ppn;
            end
          end
        end
        REQ: begin
          if (tlb_ack) begin
            ppn_q <= tlb_ppn;
          end
        end
        RESP: begin
          rr_ptr_q <= (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_req_arb.sv
// Directed self-checking bench for tlb_req_arb: reset, single request, round-robin,
// wrap-around, stall, last-translation/flush behaviour and reset mid-transaction.

module tb_tlb_req_arb;

  localparam int N_REQ = 4;
  localparam int VPN_W = 36;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*VPN_W-1:0] req_vpn;
  logic [N_REQ-1:0]       req_ack;
  logic [VPN_W-1:0]       req_ppn;
  logic                   tlb_valid;
  logic [VPN_W-1:0]       tlb_vpn;
  logic                   tlb_ack;
  logic [VPN_W-1:0]       tlb_ppn;
  logic                   flush;
  logic                   busy;

  logic [VPN_W-1:0] vpn_tb [N_REQ];

  int checks;
  int failures;

  assign req_vpn = {vpn_tb[3], vpn_tb[2], vpn_tb[1], vpn_tb[0]};

  tlb_req_arb #(
    .N_REQ(N_REQ),
    .VPN_W(VPN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_vpn  (req_vpn),
    .req_ack  (req_ack),
    .req_ppn  (req_ppn),
    .tlb_valid(tlb_valid),
    .tlb_vpn  (tlb_vpn),
    .tlb_ack  (tlb_ack),
    .tlb_ppn  (tlb_ppn),
    .flush    (flush),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [VPN_W-1:0] exp_ppn);
    check({tag, "_req_ack"},   64'(req_ack),   64'(0));
    check({tag, "_req_ppn"},   64'(req_ppn),   64'(exp_ppn));
    check({tag, "_tlb_valid"}, 64'(tlb_valid), 64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
  endtask

  // Waits (bounded) for tlb_valid, answers immediately and checks the routed ack.
  task automatic serve(input logic [VPN_W-1:0] ppn, input int exp_idx,
                       input logic [VPN_W-1:0] exp_vpn, input logic flush_on_ack);
    int n;
    n = 0;
    while (!tlb_valid && n < 50) begin
      tick();
      n++;
    end
    check("serve_tlb_valid", 64'(tlb_valid), 64'(1));
    check("serve_tlb_vpn",   64'(tlb_vpn),   64'(exp_vpn));
    tlb_ack = 1'b1;
    tlb_ppn = ppn;
    flush   = flush_on_ack;
    tick();
    tlb_ack = 1'b0;
    tlb_ppn = '0;
    flush   = 1'b0;
    check("serve_req_ack",   64'(req_ack),   64'(1) << exp_idx);
    check("serve_req_ppn",   64'(req_ppn),   64'(ppn));
    check("serve_tlb_drop",  64'(tlb_valid), 64'(0));
    req_valid[exp_idx] = 1'b0;
    tick();
    check("serve_idle_busy", 64'(busy),      64'(0));
    check("serve_idle_ack",  64'(req_ack),   64'(0));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    tlb_ack   = 1'b0;
    tlb_ppn   = '0;
    flush     = 1'b0;
    for (int i = 0; i < N_REQ; i++) vpn_tb[i] = '0;

    // Reset values
    tick();
    tick();
    check_idle_outputs("reset", '0);
    check("reset_tlb_vpn", 64'(tlb_vpn), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single request: tlb_ack at cycle 3, req_ack at cycle 4
    vpn_tb[0] = 36'h123;
    req_valid = 4'b0001;
    tick();
    for (int c = 1; c <= 3; c++) begin
      check("single_tlb_valid", 64'(tlb_valid), 64'(1));
      check("single_tlb_vpn",   64'(tlb_vpn),   64'h123);
      check("single_no_ack",    64'(req_ack),   64'(0));
      check("single_busy",      64'(busy),      64'(1));
      if (c == 3) begin
        tlb_ack = 1'b1;
        tlb_ppn = 36'h456;
      end
      tick();
    end
    tlb_ack = 1'b0;
    tlb_ppn = '0;
    check("single_req_ack",   64'(req_ack),   64'b0001);
    check("single_req_ppn",   64'(req_ppn),   64'h456);
    check("single_resp_tlbv", 64'(tlb_valid), 64'(0));
    check("single_resp_busy", 64'(busy),      64'(1));
    req_valid = 4'b0000;
    tick();
    check_idle_outputs("single_after", 36'h456);

    // Repeat of the same VPN: hits the last-translation entry only when compiled in
    req_valid = 4'b0001;
    tick();
`ifdef TLB_ARB_LAST_XLATE_EN
    check("hit_req_ack",   64'(req_ack),   64'b0001);
    check("hit_no_tlbv",   64'(tlb_valid), 64'(0));
    check("hit_req_ppn",   64'(req_ppn),   64'h456);
    req_valid = 4'b0000;
    tick();
    check_idle_outputs("hit_after", 36'h456);
`else
    check("repeat_tlb_valid", 64'(tlb_valid), 64'(1));
    check("repeat_no_ack",    64'(req_ack),   64'(0));
    serve(36'h456, 0, 36'h123, 1'b0);
`endif

    // After a flush pulse the same VPN must go to the TLB
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 4'b0001;
    tick();
    check("flush_miss_tlbv", 64'(tlb_valid), 64'(1));
    serve(36'h789, 0, 36'h123, 1'b1);

    // Flush coincident with the fill leaves the entry invalid
    req_valid = 4'b0001;
    tick();
    check("coinc_flush_miss_tlbv", 64'(tlb_valid), 64'(1));
    serve(36'h78a, 0, 36'h123, 1'b0);

    // tlb_ack outside REQ is ignored
    tlb_ack = 1'b1;
    tlb_ppn = 36'habc;
    tick();
    tlb_ack = 1'b0;
    tlb_ppn = '0;
    check_idle_outputs("stray_ack", 36'h78a);
    tick();
    check_idle_outputs("stray_ack2", 36'h78a);

    // Round-robin fairness from rr_ptr=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rr_reset_ppn", 64'(req_ppn), 64'(0));
    for (int i = 0; i < N_REQ; i++) vpn_tb[i] = VPN_W'(36'h100 + i);
    req_valid = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      serve(VPN_W'(36'h200 + i), i, VPN_W'(36'h100 + i), 1'b0);
    end
    tick();
    check_idle_outputs("rr_done", 36'h203);

    // Wrap-around: serve 2 so rr_ptr=3, then 3 must precede 0
    req_valid = 4'b0100;
    serve(36'h300, 2, 36'h102, 1'b0);
    req_valid = 4'b1001;
    serve(36'h301, 3, 36'h103, 1'b0);
    serve(36'h302, 0, 36'h100, 1'b0);

    // Stall: tlb_ack withheld for 20 cycles
    req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 20; c++) begin
      check("stall_tlb_valid", 64'(tlb_valid), 64'(1));
      check("stall_tlb_vpn",   64'(tlb_vpn),   64'h101);
      check("stall_no_ack",    64'(req_ack),   64'(0));
      check("stall_busy",      64'(busy),      64'(1));
      tick();
    end
    serve(36'h303, 1, 36'h101, 1'b0);

    // Requester drops valid early: transaction still completes with an ack
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    check("early_drop_tlbv", 64'(tlb_valid), 64'(1));
    serve(36'h304, 2, 36'h102, 1'b0);

    // Reset mid-REQ, then a late tlb_ack
    req_valid = 4'b1000;
    tick();
    check("midreq_tlbv", 64'(tlb_valid), 64'(1));
    check("midreq_vpn",  64'(tlb_vpn),   64'h103);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreq_rst", '0);
    check("midreq_rst_tlb_vpn", 64'(tlb_vpn), 64'(0));
    req_valid = 4'b0000;
    tlb_ack   = 1'b1;
    tick();
    tlb_ack = 1'b0;
    rst_n   = 1'b1;
    tick();
    tlb_ack = 1'b1;
    tlb_ppn = 36'h999;
    tick();
    tlb_ack = 1'b0;
    tlb_ppn = '0;
    for (int c = 0; c < 3; c++) begin
      check_idle_outputs("late_ack", '0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
